// File: rtl/packet_decoder_pkg.sv
// Shared serial-protocol definitions: decoder state encoding, terminator bytes
// and error-flag bit positions.
package packet_decoder_pkg;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_BAD   = 0;
  localparam int unsigned ERR_SHORT = 1;
  localparam int unsigned ERR_OVF   = 2;

  localparam logic [7:0] TERM_ASCII = 8'h0D;
  localparam logic [7:0] TERM_BIN   = 8'hFF;
  localparam logic [7:0] LF_ASCII   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HUNT   = 2'd3
  } state_e;

endpackage

// File: rtl/packet_decoder_nibble_decode.sv
// Combinational byte classifier: maps one received byte to a nibble value
// and flags it as nibble, terminator or bad character.
module nibble_decode
  import packet_decoder_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       binary_i,
  output logic [3:0] nibble_o,
  output logic       is_nibble_o,
  output logic       is_term_o,
  output logic       is_bad_o
);

  always_comb begin
    nibble_o    = 4'h0;
    is_nibble_o = 1'b0;
    is_term_o   = 1'b0;
    is_bad_o    = 1'b0;
    if (binary_i) begin
      if (byte_i[7:4] == 4'h0) begin
        nibble_o    = byte_i[3:0];
        is_nibble_o = 1'b1;
      end else if (byte_i == TERM_BIN) begin
        is_term_o = 1'b1;
      end else begin
        is_bad_o = 1'b1;
      end
    end else begin
      // Letters A-F / a-f share the low nibble 1..6, so add 9 to reach 10..15.
      if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
        nibble_o    = byte_i[3:0];
        is_nibble_o = 1'b1;
      end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                   (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
        nibble_o    = byte_i[3:0] + 4'd9;
        is_nibble_o = 1'b1;
      end else if (byte_i == TERM_ASCII) begin
        is_term_o = 1'b1;
      end else if (byte_i != LF_ASCII) begin
        is_bad_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_decoder.sv
// Assembles nibble-encoded bytes from a UART receiver into fixed-width
// packets, reporting header arrival, completion and framing errors.
module packet_decoder
  import packet_decoder_pkg::*;
#(
  parameter int unsigned RESOLUTION     = 64,
  parameter int unsigned HEADER_NIBBLES = 4,
  parameter bit          BINARY         = 1'b0
) (
  input  logic                        intclk,
  input  logic                        reset_n,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_valid,
  output logic [RESOLUTION-1:0]       rx_data,
  output logic                        rx_done,
  output logic                        header_strobe,
  output logic [HEADER_NIBBLES*4-1:0] header,
  output logic [ERR_W-1:0]            err,
  output logic                        busy
);

  localparam int unsigned NIBBLES = RESOLUTION / 4;
  localparam int unsigned CNT_W   = $clog2(NIBBLES) + 1;
  localparam int unsigned HDR_W   = HEADER_NIBBLES * 4;

  state_e                state_q, state_d;
  logic [RESOLUTION-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RESOLUTION-1:0] rx_data_q, rx_data_d;
  logic                  rx_done_q, rx_done_d;
  logic                  hdr_pend_q, hdr_pend_d;
  logic                  header_strobe_q, header_strobe_d;
  logic [HDR_W-1:0]      header_q, header_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  busy_q, busy_d;

  logic [3:0] nibble;
  logic       is_nibble;
  logic       is_term;
  logic       is_bad;

  nibble_decode u_nibble_decode (
    .byte_i      (rx_byte),
    .binary_i    (BINARY),
    .nibble_o    (nibble),
    .is_nibble_o (is_nibble),
    .is_term_o   (is_term),
    .is_bad_o    (is_bad)
  );

  always_ff @(posedge intclk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      shift_q         <= '0;
      cnt_q           <= '0;
      rx_data_q       <= '0;
      rx_done_q       <= 1'b0;
      hdr_pend_q      <= 1'b0;
      header_strobe_q <= 1'b0;
      header_q        <= '0;
      err_q           <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      cnt_q           <= cnt_d;
      rx_data_q       <= rx_data_d;
      rx_done_q       <= rx_done_d;
      hdr_pend_q      <= hdr_pend_d;
      header_strobe_q <= header_strobe_d;
      header_q        <= header_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
    end
  end

  // Header is published one cycle after its last nibble lands in the shifter.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    cnt_d           = cnt_q;
    rx_data_d       = rx_data_q;
    rx_done_d       = 1'b0;
    hdr_pend_d      = 1'b0;
    header_strobe_d = hdr_pend_q;
    header_d        = hdr_pend_q ? shift_q[HDR_W-1:0] : header_q;
    err_d           = err_q;

    unique case (state_q)
      ST_IDLE, ST_COMMIT: begin
        if (state_q == ST_COMMIT) begin
          rx_data_d = shift_q;
          rx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
        // COMMIT accepts a new byte exactly like IDLE so nothing is lost.
        if (rx_valid) begin
          if (is_nibble) begin
            shift_d    = RESOLUTION'(nibble);
            cnt_d      = CNT_W'(1);
            err_d      = '0;
            hdr_pend_d = (HEADER_NIBBLES == 1);
            state_d    = ST_RECV;
          end else if (is_bad) begin
            err_d[ERR_BAD] = 1'b1;
            state_d        = ST_HUNT;
          end
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (is_nibble) begin
            if (cnt_q == CNT_W'(NIBBLES)) begin
              err_d[ERR_OVF] = 1'b1;
              state_d        = ST_HUNT;
            end else begin
              shift_d    = {shift_q[RESOLUTION-5:0], nibble};
              cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
              hdr_pend_d = (cnt_q == CNT_W'(HEADER_NIBBLES - 1));
            end
          end else if (is_term) begin
            if (cnt_q == CNT_W'(NIBBLES)) begin
              state_d = ST_COMMIT;
            end else begin
              err_d[ERR_SHORT] = 1'b1;
              state_d          = ST_IDLE;
            end
          end else if (is_bad) begin
            err_d[ERR_BAD] = 1'b1;
            state_d        = ST_HUNT;
          end
        end
      end
      ST_HUNT: begin
        if (rx_valid && is_term) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign header_strobe = header_strobe_q;
  assign header        = header_q;
  assign err           = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_packet_decoder.sv
// Self-checking bench for packet_decoder: an ASCII and a binary instance,
// directed scenarios plus random packets against a queue-based model.
module tb_packet_decoder;

  localparam int unsigned RES = 16;
  localparam int unsigned HN  = 2;
  localparam int unsigned NN  = RES / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [7:0]     rx_byte_a, rx_byte_b;
  logic           rx_valid_a, rx_valid_b;
  logic [RES-1:0] rx_data_a, rx_data_b;
  logic           rx_done_a, rx_done_b;
  logic           hs_a, hs_b;
  logic [HN*4-1:0] header_a, header_b;
  logic [2:0]     err_a, err_b;
  logic           busy_a, busy_b;

  packet_decoder #(.RESOLUTION(RES), .HEADER_NIBBLES(HN), .BINARY(1'b0)) dut_a (
    .intclk(clk), .reset_n(reset_n), .rx_byte(rx_byte_a), .rx_valid(rx_valid_a),
    .rx_data(rx_data_a), .rx_done(rx_done_a), .header_strobe(hs_a),
    .header(header_a), .err(err_a), .busy(busy_a));

  packet_decoder #(.RESOLUTION(RES), .HEADER_NIBBLES(HN), .BINARY(1'b1)) dut_b (
    .intclk(clk), .reset_n(reset_n), .rx_byte(rx_byte_b), .rx_valid(rx_valid_b),
    .rx_data(rx_data_b), .rx_done(rx_done_b), .header_strobe(hs_b),
    .header(header_b), .err(err_b), .busy(busy_b));

  int vectors = 0;
  int miscompares = 0;

  int done_cnt[2] = '{0, 0};
  int hs_cnt[2]   = '{0, 0};

  always @(negedge clk) begin
    if (rx_done_a) done_cnt[0]++;
    if (rx_done_b) done_cnt[1]++;
    if (hs_a) hs_cnt[0]++;
    if (hs_b) hs_cnt[1]++;
  end

  // Reference model: pending nibbles held in a queue per instance.
  logic [3:0]  nibs[2][$];
  bit          hunting[2];
  bit          hpend[2];
  logic [7:0]  hpend_val[2];
  logic [2:0]  m_err[2];
  logic [15:0] m_data[2];
  logic [7:0]  m_hdr[2];
  int          m_done[2];
  int          m_hs[2];

  function automatic int classify(int k, logic [7:0] b, output logic [3:0] n);
    n = 4'h0;
    if (k == 1) begin
      if (b < 8'h10) begin n = b[3:0]; return 0; end
      if (b == 8'hFF) return 1;
      return 3;
    end
    if (b >= 8'h30 && b <= 8'h39) begin n = 4'(b - 8'h30); return 0; end
    if (b >= 8'h41 && b <= 8'h46) begin n = 4'(b - 8'h37); return 0; end
    if (b >= 8'h61 && b <= 8'h66) begin n = 4'(b - 8'h57); return 0; end
    if (b == 8'h0D) return 1;
    if (b == 8'h0A) return 2;
    return 3;
  endfunction

  function automatic logic [15:0] qval(int k, int cnt);
    logic [15:0] v = 16'h0;
    for (int i = 0; i < cnt; i++) v = (v << 4) | 16'(nibs[k][i]);
    return v;
  endfunction

  task automatic settle(int k);
    if (hpend[k]) begin
      m_hs[k]++;
      m_hdr[k] = hpend_val[k];
      hpend[k] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      nibs[k].delete();
      hunting[k] = 1'b0;
      hpend[k]   = 1'b0;
      m_err[k]   = 3'b000;
      m_data[k]  = 16'h0;
      m_hdr[k]   = 8'h0;
    end
  endtask

  task automatic mdl_byte(int k, logic [7:0] b);
    logic [3:0] n;
    int cls;
    settle(k);
    cls = classify(k, b, n);
    if (hunting[k]) begin
      if (cls == 1) hunting[k] = 1'b0;
    end else begin
      case (cls)
        0: begin
          if (nibs[k].size() == NN) begin
            m_err[k][2] = 1'b1;
            hunting[k]  = 1'b1;
            nibs[k].delete();
          end else begin
            if (nibs[k].size() == 0) m_err[k] = 3'b000;
            nibs[k].push_back(n);
            if (nibs[k].size() == HN) begin
              hpend[k]     = 1'b1;
              hpend_val[k] = 8'(qval(k, HN));
            end
          end
        end
        1: begin
          if (nibs[k].size() == NN) begin
            m_data[k] = qval(k, NN);
            m_done[k]++;
          end else if (nibs[k].size() > 0) begin
            m_err[k][1] = 1'b1;
          end
          nibs[k].delete();
        end
        3: begin
          m_err[k][0] = 1'b1;
          hunting[k]  = 1'b1;
          nibs[k].delete();
        end
        default: ;
      endcase
    end
  endtask

  // Called at a falling edge; the byte is sampled on the following rising edge.
  task automatic send(int k, logic [7:0] b, int gap);
    if (k == 0) begin rx_byte_a = b; rx_valid_a = 1'b1; end
    else        begin rx_byte_b = b; rx_valid_b = 1'b1; end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    mdl_byte(k, b);
    repeat (gap) @(negedge clk);
    if (gap > 0) settle(k);
  endtask

  task automatic send_str(int k, string s, int gap);
    for (int i = 0; i < s.len(); i++) send(k, s[i], gap);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
    settle(0);
    settle(1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_data_a, rx_done_a, hs_a, header_a, err_a, busy_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: got data=%h done=%b hs=%b hdr=%h err=%b busy=%b, expected all zero",
               rx_data_a, rx_done_a, hs_a, header_a, err_a, busy_a);
    end
    vectors++;
    if ({rx_data_b, rx_done_b, hs_b, header_b, err_b, busy_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: got data=%h done=%b hs=%b hdr=%h err=%b busy=%b, expected all zero",
               rx_data_b, rx_done_b, hs_b, header_b, err_b, busy_b);
    end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    send_str(0, "1A", 0);
    idle(2);
    vectors++;
    if (header_a !== 8'h1A || hs_cnt[0] !== 1 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL header: got hdr=%h strobes=%0d busy=%b, expected hdr=1a strobes=1 busy=1",
               header_a, hs_cnt[0], busy_a);
    end
    send_str(0, "2F", 0);
    send(0, 8'h0D, 0);
    vectors++;
    if (rx_done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL done_early: got rx_done=%b one cycle after CR, expected 0", rx_done_a);
    end
    @(negedge clk);
    vectors++;
    if (rx_done_a !== 1'b1 || rx_data_a !== 16'h1A2F) begin
      miscompares++;
      $display("FAIL done_timing: got rx_done=%b data=%h two cycles after CR, expected 1 / 1a2f",
               rx_done_a, rx_data_a);
    end
    @(negedge clk);
    vectors++;
    if (rx_done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: got rx_done=%b three cycles after CR, expected 0", rx_done_a);
    end
    idle(1);
    vectors++;
    if (err_a !== 3'b000 || busy_a !== 1'b0 || done_cnt[0] !== m_done[0]) begin
      miscompares++;
      $display("FAIL basic_end: got err=%b busy=%b dones=%0d, expected err=000 busy=0 dones=%0d",
               err_a, busy_a, done_cnt[0], m_done[0]);
    end
  endtask

  task automatic test_short();
    send_str(0, "1A2", 1);
    send(0, 8'h0D, 1);
    idle(3);
    vectors++;
    if (err_a !== 3'b010 || rx_data_a !== 16'h1A2F || done_cnt[0] !== m_done[0]) begin
      miscompares++;
      $display("FAIL short: got err=%b data=%h dones=%0d, expected err=010 data=1a2f dones=%0d",
               err_a, rx_data_a, done_cnt[0], m_done[0]);
    end
    send_str(0, "BEEF", 1);
    send(0, 8'h0D, 1);
    idle(3);
    vectors++;
    if (err_a !== 3'b000 || rx_data_a !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL after_short: got err=%b data=%h, expected err=000 data=beef", err_a, rx_data_a);
    end
  endtask

  task automatic test_overflow();
    send_str(0, "1A2F3", 1);
    idle(2);
    vectors++;
    if (err_a !== 3'b100 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got err=%b busy=%b, expected err=100 busy=1", err_a, busy_a);
    end
    send_str(0, "12", 0);
    send(0, 8'h0D, 0);
    idle(3);
    vectors++;
    if (rx_data_a !== 16'hBEEF || done_cnt[0] !== m_done[0] || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt: got data=%h dones=%0d busy=%b, expected data=beef dones=%0d busy=0",
               rx_data_a, done_cnt[0], busy_a, m_done[0]);
    end
    send_str(0, "0001", 0);
    send(0, 8'h0D, 0);
    idle(3);
    vectors++;
    if (rx_data_a !== 16'h0001 || err_a !== 3'b000) begin
      miscompares++;
      $display("FAIL after_hunt: got data=%h err=%b, expected data=0001 err=000", rx_data_a, err_a);
    end
  endtask

  task automatic test_binary();
    send(1, 8'h0C, 0);
    send(1, 8'h00, 0);
    send(1, 8'h0F, 0);
    send(1, 8'h0E, 0);
    send(1, 8'hFF, 0);
    idle(3);
    vectors++;
    if (rx_data_b !== 16'hC0FE || err_b !== 3'b000 || done_cnt[1] !== 1 || header_b !== 8'hC0) begin
      miscompares++;
      $display("FAIL binary: got data=%h err=%b dones=%0d hdr=%h, expected c0fe 000 1 c0",
               rx_data_b, err_b, done_cnt[1], header_b);
    end
    send(1, 8'h01, 0);
    send(1, 8'h41, 0);
    idle(2);
    vectors++;
    if (err_b !== 3'b001 || busy_b !== 1'b1) begin
      miscompares++;
      $display("FAIL binary_bad: got err=%b busy=%b, expected err=001 busy=1", err_b, busy_b);
    end
    send(1, 8'hFF, 0);
    idle(2);
    vectors++;
    if (busy_b !== 1'b0 || rx_data_b !== 16'hC0FE) begin
      miscompares++;
      $display("FAIL binary_exit: got busy=%b data=%h, expected busy=0 data=c0fe", busy_b, rx_data_b);
    end
  endtask

  task automatic test_back_to_back();
    send_str(0, "CAFE", 0);
    send(0, 8'h0D, 0);
    send_str(0, "D00D", 0);
    send(0, 8'h0D, 0);
    idle(3);
    vectors++;
    if (rx_data_a !== 16'hD00D || done_cnt[0] !== m_done[0] || header_a !== 8'hD0 ||
        hs_cnt[0] !== m_hs[0] || err_a !== 3'b000) begin
      miscompares++;
      $display("FAIL back_to_back: got data=%h dones=%0d hdr=%h hs=%0d err=%b, expected d00d %0d d0 %0d 000",
               rx_data_a, done_cnt[0], header_a, hs_cnt[0], err_a, m_done[0], m_hs[0]);
    end
  endtask

  task automatic test_reset_mid();
    int hs_before;
    int done_before;
    hs_before   = hs_cnt[0];
    done_before = done_cnt[0];
    send(0, "1", 0);
    send(0, "2", 0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0 || rx_data_a !== 16'h0 || err_a !== 3'b000 || header_a !== 8'h0 ||
        hs_cnt[0] !== hs_before || done_cnt[0] !== done_before) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b data=%h err=%b hdr=%h hs=%0d dones=%0d, expected 0 0 0 0 %0d %0d",
               busy_a, rx_data_a, err_a, header_a, hs_cnt[0], done_cnt[0], hs_before, done_before);
    end
    reset_n = 1'b1;
    @(negedge clk);
    send_str(0, "0042", 0);
    send(0, 8'h0D, 0);
    idle(3);
    vectors++;
    if (rx_data_a !== 16'h0042 || hs_cnt[0] !== hs_before + 1 || header_a !== 8'h00 ||
        done_cnt[0] !== done_before + 1) begin
      miscompares++;
      $display("FAIL after_reset: got data=%h hs=%0d hdr=%h dones=%0d, expected 0042 %0d 00 %0d",
               rx_data_a, hs_cnt[0], header_a, done_cnt[0], hs_before + 1, done_before + 1);
    end
  endtask

  task automatic test_random();
    logic [7:0] bad_ascii[6] = '{8'h47, 8'h20, 8'h7A, 8'hFF, 8'h00, 8'h2F};
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 40; p++) begin
        int kind;
        int len;
        int bad_pos;
        kind    = int'($urandom_range(0, 5));
        len     = (kind == 3) ? int'($urandom_range(1, 3)) :
                  (kind == 4) ? int'($urandom_range(5, 6)) : 4;
        bad_pos = (kind == 5) ? int'($urandom_range(0, 3)) : -1;
        for (int i = 0; i < len; i++) begin
          logic [3:0] n;
          logic [7:0] c;
          n = 4'($urandom);
          if (k == 1)      c = {4'h0, n};
          else if (n < 10) c = 8'h30 + 8'(n);
          else             c = ($urandom_range(0, 1) == 1) ? 8'h37 + 8'(n) : 8'h57 + 8'(n);
          if (k == 0 && $urandom_range(0, 7) == 0) send(k, 8'h0A, int'($urandom_range(0, 2)));
          if (i == bad_pos)
            send(k, (k == 1) ? 8'h10 + 8'($urandom_range(0, 8'hEE)) : bad_ascii[$urandom_range(0, 5)],
                 int'($urandom_range(0, 2)));
          send(k, c, int'($urandom_range(0, 2)));
        end
        if ($urandom_range(0, 7) != 0) send(k, (k == 1) ? 8'hFF : 8'h0D, int'($urandom_range(0, 2)));
        idle(3);
        vectors++;
        if (((k == 0) ? rx_data_a : rx_data_b) !== m_data[k]) begin
          miscompares++;
          $display("FAIL rnd_data[%0d] pkt %0d: got %h expected %h", k, p,
                   (k == 0) ? rx_data_a : rx_data_b, m_data[k]);
        end
        vectors++;
        if (((k == 0) ? err_a : err_b) !== m_err[k]) begin
          miscompares++;
          $display("FAIL rnd_err[%0d] pkt %0d: got %b expected %b", k, p,
                   (k == 0) ? err_a : err_b, m_err[k]);
        end
        vectors++;
        if (done_cnt[k] !== m_done[k] || hs_cnt[k] !== m_hs[k]) begin
          miscompares++;
          $display("FAIL rnd_pulses[%0d] pkt %0d: got dones=%0d strobes=%0d expected %0d %0d",
                   k, p, done_cnt[k], hs_cnt[k], m_done[k], m_hs[k]);
        end
        vectors++;
        if (((k == 0) ? header_a : header_b) !== m_hdr[k]) begin
          miscompares++;
          $display("FAIL rnd_hdr[%0d] pkt %0d: got %h expected %h", k, p,
                   (k == 0) ? header_a : header_b, m_hdr[k]);
        end
        vectors++;
        if (((k == 0) ? busy_a : busy_b) !== (hunting[k] || nibs[k].size() > 0)) begin
          miscompares++;
          $display("FAIL rnd_busy[%0d] pkt %0d: got %b expected %b", k, p,
                   (k == 0) ? busy_a : busy_b, (hunting[k] || nibs[k].size() > 0));
        end
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    rx_byte_a  = 8'h00;
    rx_byte_b  = 8'h00;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    model_reset();
    m_done = '{0, 0};
    m_hs   = '{0, 0};
    test_reset();
    test_basic();
    test_short();
    test_overflow();
    test_binary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packet_decoder.md
PACKET_DECODER -- requirements
Module: packet_decoder

Interface
REQ-001 The block SHALL take parameter RESOLUTION, default 64, giving the packet width in bits; it must be a multiple of 4.
REQ-002 The block SHALL take parameter HEADER_NIBBLES, default 4, giving the count of leading nibbles that form the header; range 1..RESOLUTION/4-1.
REQ-003 The block SHALL take parameter BINARY, default 0: 0 = ASCII-hex nibble bytes, 1 = raw nibble bytes.
REQ-004 The block SHALL have port intclk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port rx_byte, input, 8 bits: received byte, as delivered by uart_rx (RXREG).
REQ-007 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking rx_byte valid, already synchronised to intclk.
REQ-008 The block SHALL have port rx_data, output, RESOLUTION bits: last complete packet; the first nibble received lands in the MSBs.
REQ-009 The block SHALL have port rx_done, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-010 The block SHALL have port header_strobe, output, 1 bit: one-cycle pulse when header nibbles are complete.
REQ-011 The block SHALL have port header, output, HEADER_NIBBLES*4 bits: header of the packet currently being received.
REQ-012 The block SHALL have port err, output, 3 bits: sticky error flags {overflow, short, bad_char}, cleared at the next valid packet start.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 Byte decoding SHALL be as follows:
- BINARY=0: '0'-'9', 'A'-'F' and 'a'-'f' are nibbles; 0x0D (CR) is the terminator; 0x0A is ignored; anything else is bad_char.
- BINARY=1: 0x00-0x0F are nibbles; 0xFF is the terminator; anything else is bad_char.
REQ-015 The state machine SHALL have exactly the states IDLE, RECV, COMMIT and HUNT.
REQ-016 In IDLE, a nibble SHALL load the shift register, set nibble count to 1, clear err, and move to RECV; a terminator SHALL be ignored; bad_char SHALL set err[0] and move to HUNT.
REQ-017 In RECV, each nibble SHALL shift the register left 4 and insert the new nibble in the LSBs, then increment the count.
REQ-018 header_strobe SHALL pulse, and header SHALL latch, on the cycle after the count reaches HEADER_NIBBLES.
REQ-019 In RECV, a terminator with count == RESOLUTION/4 SHALL move to COMMIT.
REQ-020 In RECV, a terminator with a smaller count SHALL set err[1] and move to IDLE; rx_data SHALL NOT change.
REQ-021 In RECV, a nibble arriving when count == RESOLUTION/4 SHALL set err[2] and move to HUNT.
REQ-022 In RECV, bad_char SHALL set err[0] and move to HUNT.
REQ-023 COMMIT SHALL copy the shift register to rx_data, pulse rx_done for exactly one cycle and return to IDLE; rx_done is therefore asserted 2 cycles after the terminator strobe.
REQ-024 An rx_valid arriving while in COMMIT SHALL be processed exactly as if it arrived in IDLE; no byte is dropped.
REQ-025 HUNT SHALL discard all bytes until a terminator, then move to IDLE.
REQ-026 The nibble counter SHALL be $clog2(RESOLUTION/4)+1 bits wide and SHALL saturate; it never wraps.
REQ-027 rx_data SHALL hold its value between rx_done pulses.

Reset
REQ-028 While reset_n is low at a rising edge, the state SHALL become IDLE and all outputs, the shift register and the counter SHALL be 0.
REQ-029 Reset asserted in the middle of a packet SHALL abandon the packet without asserting rx_done, err or header_strobe.

Structure
REQ-030 The state encoding, the terminator constants (0x0D, 0xFF) and the error-bit indices SHALL live in the shared protocol package that TX_WORD also uses.
REQ-031 Byte-to-nibble classification SHALL be one combinational sub-module, nibble_decode, with ports {byte, binary} -> {nibble, is_nibble, is_term, is_bad}.

Verification
REQ-032 Scenario: RESOLUTION=16, BINARY=0, send "1A2F" then CR -> rx_data=0x1A2F, rx_done pulses 2 cycles after the CR strobe, err=0.
REQ-033 Scenario: HEADER_NIBBLES=2, send "1A" -> header=0x1A, header_strobe pulses once, busy=1.
REQ-034 Scenario: send "1A2" then CR -> err=3'b010, rx_data unchanged, no rx_done; next "BEEF" then CR -> rx_data=0xBEEF, err=0.
REQ-035 Scenario: send "1A2F3" -> err=3'b100, state HUNT; "12" then CR is ignored; following "0001" then CR -> rx_data=0x0001.
REQ-036 Scenario: BINARY=1, send 0x0C, 0x00, 0x0F, 0x0E, 0xFF -> rx_data=0xC0FE; the byte 0x41 mid-packet -> err=3'b001.
REQ-037 Scenario: reset_n low after 2 nibbles, then high and send "0042" then CR -> rx_data=0x0042, no stale nibbles, header_strobe counted once.
